// File: rtl/harmonic_mixer.sv
// Harmonic mixer: combines four signed harmonic samples into one output sample.
// Each harmonic gets a 7-bit percentage weight and an optional sign flip.
// The four weighted terms are summed serially, one term per clock.
// The sum is then scaled by roughly 1/100 (655/65536), floored, and
// saturated to 16 bits.
module harmonic_mixer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] coeff,
  input  logic [15:0] s1,
  input  logic [15:0] s2,
  input  logic [15:0] s3,
  input  logic [15:0] s4,
  input  logic        start,
  output logic        busy,
  output logic        out_valid,
  output logic [15:0] out_sample
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Operands latched when a mix is accepted, so the inputs are free to move afterwards
  logic [31:0]        coeff_q;
  logic signed [15:0] s1_q;
  logic signed [15:0] s2_q;
  logic signed [15:0] s3_q;
  logic signed [15:0] s4_q;

  // Running sum; 4 * 32768 * 127 fits comfortably in 25 signed bits
  logic signed [24:0] acc;
  logic [2:0]         k;

  // Per-harmonic operand selected by the current index
  logic signed [15:0] sel_sample;
  logic [6:0]         sel_weight;
  logic               sel_neg;
  logic signed [23:0] raw_term;
  logic signed [24:0] term_ext;
  logic signed [24:0] term;

  // Output scaling path
  logic signed [35:0] acc_wide;
  logic signed [35:0] scaled_prod;
  logic signed [35:0] shifted;
  logic [15:0]        sat_sample;

  assign busy = (state != IDLE);

  // Pick the sample, weight and negate flag for harmonic k
  always_comb begin
    sel_sample = s1_q;
    sel_weight = coeff_q[31:25];
    sel_neg    = coeff_q[3];
    case (k)
      3'd2: begin
        sel_sample = s2_q;
        sel_weight = coeff_q[24:18];
        sel_neg    = coeff_q[2];
      end
      3'd3: begin
        sel_sample = s3_q;
        sel_weight = coeff_q[17:11];
        sel_neg    = coeff_q[1];
      end
      3'd4: begin
        sel_sample = s4_q;
        sel_weight = coeff_q[10:4];
        sel_neg    = coeff_q[0];
      end
      default: begin
        sel_sample = s1_q;
        sel_weight = coeff_q[31:25];
        sel_neg    = coeff_q[3];
      end
    endcase
  end

  // Signed sample times zero-extended weight, then the optional negation
  assign raw_term = sel_sample * $signed({1'b0, sel_weight});
  assign term_ext = {raw_term[23], raw_term};
  assign term     = sel_neg ? -term_ext : term_ext;

  // Scale by 655/65536; arithmetic shift floors toward negative infinity
  assign acc_wide    = $signed({{11{acc[24]}}, acc});
  assign scaled_prod = acc_wide * 36'sd655;
  assign shifted     = scaled_prod >>> 16;

  // Clamp the scaled sum into the 16-bit signed range
  always_comb begin
    if (shifted > 36'sd32767) begin
      sat_sample = 16'h7fff;
    end else if (shifted < -36'sd32768) begin
      sat_sample = 16'h8000;
    end else begin
      sat_sample = shifted[15:0];
    end
  end

  // Control FSM with operand capture, serial accumulation and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      coeff_q    <= 32'd0;
      s1_q       <= 16'sd0;
      s2_q       <= 16'sd0;
      s3_q       <= 16'sd0;
      s4_q       <= 16'sd0;
      acc        <= 25'sd0;
      k          <= 3'd1;
      out_valid  <= 1'b0;
      out_sample <= 16'd0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            coeff_q <= coeff;
            s1_q    <= s1;
            s2_q    <= s2;
            s3_q    <= s3;
            s4_q    <= s4;
            acc     <= 25'sd0;
            k       <= 3'd1;
            state   <= MAC;
          end
        end
        MAC: begin
          acc <= acc + term;
          if (k == 3'd4) begin
            k     <= 3'd1;
            state <= DONE;
          end else begin
            k <= k + 3'd1;
          end
        end
        DONE: begin
          out_sample <= sat_sample;
          out_valid  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/harmonic_mixer.md
HARMONIC_MIXER -- requirements
Module: harmonic_mixer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; ports are listed below, clock and reset first.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 coeff  in  32  packed harmonic word {w1[31:25], w2[24:18], w3[17:11], w4[10:4], n1[3], n2[2], n3[1], n4[0]}; wk unsigned weight in percent, nk = negate harmonic k.
REQ-005 s1, s2, s3, s4  in  16 each  signed two's-complement samples of harmonics 1-4.
REQ-006 start  in  1  request one mixed sample; accepted only when busy=0.
REQ-007 busy  out  1  high while a mix is in progress.
REQ-008 out_valid  out  1  one-cycle pulse marking a new result.
REQ-009 out_sample  out  16  signed mixed result; held until the next result.

Function
REQ-010 The FSM SHALL have the states IDLE, MAC and DONE; busy = (state != IDLE).
REQ-011 At edge E0 with start=1 in IDLE: capture coeff and s1-s4 into internal registers, clear acc, set harmonic index k=1, go to MAC.
REQ-012 start=1 outside IDLE SHALL be ignored, with no effect on the captured operands or the result.
REQ-013 In MAC, each edge E1-E4 SHALL add term_k to acc for k=1,2,3,4 in order; after E4, go to DONE.
REQ-014 term_k = sk * wk (signed 16 x unsigned 7, weight zero-extended), negated when nk=1; acc is 25-bit signed, and overflow is impossible by construction.
REQ-015 At edge E5 in DONE: out_sample <= sat16((acc * 655) >>> 16), out_valid <= 1, state <= IDLE.
REQ-016 The acc*655 product SHALL be at least 36-bit signed; >>> is an arithmetic shift, so the result floors toward negative infinity.
REQ-017 sat16 SHALL clamp to [-32768, 32767].
REQ-018 Latency: out_valid is high in the cycle after E5, i.e. 5 edges after the accepting edge.
REQ-019 out_valid SHALL be high for exactly one cycle per accepted start.
REQ-020 A start sampled at E5 is ignored, because the state is still DONE; the earliest next accept is E6.
REQ-021 With start held high, throughput SHALL be one result per 6 cycles.
REQ-022 Operand inputs may change freely after E0 with no effect on the current mix.
REQ-023 Weight 0 contributes 0 regardless of the sign bit; the weights are not required to sum to 100.

Reset
REQ-024 While rst=1, asynchronously: state=IDLE, busy=0, out_valid=0, out_sample=0, acc=0, k=1, captured operands=0.
REQ-025 Reset asserted mid-MAC or in DONE SHALL abort the mix; no out_valid is produced for the aborted request.
REQ-026 The first start after rst deasserts SHALL be accepted normally on its edge.

Verification
REQ-027 coeff={100,0,0,0,4'b0000}, s1=10000, others=0, start one cycle -> out_valid 5 edges later, out_sample=9994.
REQ-028 coeff={55,30,19,14,4'b0101}, s1-s4=1000 -> acc=30000, out_sample=299.
REQ-029 coeff={127,127,127,127,4'b0000}, s1-s4=32767 -> out_sample=32767 (saturated); same weights with s1-s4=-32768 -> out_sample=-32768.
REQ-030 coeff={100,0,0,0,4'b0000}, s1=-1 -> acc=-100, out_sample=-1 (floor check); repeat with n1=1 -> out_sample=0.
REQ-031 start pulsed at E0, pulsed again at E2 with different operands, and operands changed at E1 -> single result matching the E0 operands; no second out_valid.
REQ-032 start held high for 18 cycles -> exactly 3 out_valid pulses spaced 6 cycles apart; rst pulsed during MAC -> busy=0 and out_sample=0 immediately, and no out_valid follows.
